// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode, direction and parameter-range definitions for counter_multimode
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'b00,
        MODE_UP       = 2'b01,
        MODE_DOWN     = 2'b10,
        MODE_PINGPONG = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 32;
    localparam int PRESCALE_MIN = 2;
    localparam int PRESCALE_MAX = 256;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - qualifying-cycle divider, tick on every PRESCALE-th enabled cycle
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_multimode.sv
// rtl/counter_multimode.sv - up/down/ping-pong counter with load clamp and sticky wrap; COUNTER_PRESCALER_EN adds step divider
module counter_multimode
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_value,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flag,
    output logic [WIDTH-1:0] out_result,
    output logic             tc,
    output logic             wrap_sticky,
    output logic             dir
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             sticky_q, sticky_d;
    logic             dir_q, dir_d;
    mode_e            mode_s;
    logic             qualify;
    logic             step_tick;
    logic             step;

    assign mode_s  = mode_e'(mode);
    assign qualify = en && !load && (mode_s != MODE_HOLD);

`ifdef COUNTER_PRESCALER_EN
    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (load),
        .en   (qualify),
        .tick (step_tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = |32'(PRESCALE);
    assign step_tick       = 1'b1;
`endif

    assign step = qualify && step_tick;

    always_comb begin
        cnt_d    = cnt_q;
        tc_d     = 1'b0;
        dir_d    = dir_q;
        sticky_d = clear_flag ? 1'b0 : sticky_q;
        if (load) begin
            cnt_d = (load_value > max_value) ? max_value : load_value;
        end else if (step) begin
            if (max_value == '0) begin
                cnt_d = '0;
                tc_d  = 1'b1;
            end else begin
                case (mode_s)
                    MODE_UP: begin
                        if (cnt_q >= max_value) begin
                            cnt_d = '0;
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                    // A count left above a lowered max_value is pulled back to it on a down step
                    MODE_DOWN: begin
                        if (cnt_q == '0) begin
                            cnt_d = max_value;
                            tc_d  = 1'b1;
                        end else if (cnt_q > max_value) begin
                            cnt_d = max_value;
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                    MODE_PINGPONG: begin
                        if (dir_q == DIR_UP) begin
                            if (cnt_q >= max_value) begin
                                cnt_d = max_value - WIDTH'(1);
                                dir_d = DIR_DOWN;
                                tc_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + WIDTH'(1);
                            end
                        end else begin
                            if (cnt_q == '0) begin
                                cnt_d = WIDTH'(1);
                                dir_d = DIR_UP;
                                tc_d  = 1'b1;
                            end else if (cnt_q > max_value) begin
                                cnt_d = max_value;
                            end else begin
                                cnt_d = cnt_q - WIDTH'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (mode_s != MODE_PINGPONG) begin
            dir_d = DIR_UP;
        end
        if (tc_d) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            tc_q     <= 1'b0;
            sticky_q <= 1'b0;
            dir_q    <= DIR_UP;
        end else begin
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            sticky_q <= sticky_d;
            dir_q    <= dir_d;
        end
    end

    assign out_result  = cnt_q;
    assign tc          = tc_q;
    assign wrap_sticky = sticky_q;
    assign dir         = dir_q;

endmodule

// File: tb/tb_counter_multimode.sv
// tb/tb_counter_multimode.sv - directed self-checking bench for counter_multimode (WIDTH=8, PRESCALE=4)
module tb_counter_multimode;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] max_value;
    logic       load;
    logic [7:0] load_value;
    logic       clear_flag;
    logic [7:0] out_result;
    logic       tc;
    logic       wrap_sticky;
    logic       dir;

    int total = 0;
    int bad   = 0;

    counter_multimode #(
        .WIDTH   (8),
        .PRESCALE(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .max_value  (max_value),
        .load       (load),
        .load_value (load_value),
        .clear_flag (clear_flag),
        .out_result (out_result),
        .tc         (tc),
        .wrap_sticky(wrap_sticky),
        .dir        (dir)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] up_exp[6];
    logic [7:0] pp_exp[7];
    logic       pp_dir[7];
    logic       pp_tc[7];

    initial begin
        up_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        pp_exp = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
        pp_dir = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        pp_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; en = 1'b0; mode = 2'b00; max_value = 8'd5;
        load = 1'b0; load_value = 8'd0; clear_flag = 1'b0;
        step_clk();
        step_clk();
        chk("rst_out", 32'(out_result), 32'd0);
        chk("rst_tc", 32'(tc), 32'd0);
        chk("rst_sticky", 32'(wrap_sticky), 32'd0);
        chk("rst_dir", 32'(dir), 32'd1);

`ifndef COUNTER_PRESCALER_EN
        // up wrap at max_value=5
        reset = 1'b0; mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_clk();
            chk($sformatf("up_out[%0d]", i), 32'(out_result), 32'(up_exp[i]));
            chk($sformatf("up_tc[%0d]", i), 32'(tc), (i == 5) ? 32'd1 : 32'd0);
        end
        chk("up_sticky", 32'(wrap_sticky), 32'd1);
        en = 1'b0;
        step_clk();
        chk("hold_out", 32'(out_result), 32'd0);
        chk("hold_tc", 32'(tc), 32'd0);
        chk("hold_sticky", 32'(wrap_sticky), 32'd1);

        // ping-pong at max_value=3
        reset = 1'b1;
        step_clk();
        reset = 1'b0; max_value = 8'd3; mode = 2'b11; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step_clk();
            chk($sformatf("pp_out[%0d]", i), 32'(out_result), 32'(pp_exp[i]));
            chk($sformatf("pp_dir[%0d]", i), 32'(dir), 32'(pp_dir[i]));
            chk($sformatf("pp_tc[%0d]", i), 32'(tc), 32'(pp_tc[i]));
        end
        step_clk();
        step_clk();
        step_clk();
        chk("pp_mid_out", 32'(out_result), 32'd2);
        chk("pp_mid_dir", 32'(dir), 32'd0);
        reset = 1'b1;
        step_clk();
        chk("midrst_out", 32'(out_result), 32'd0);
        chk("midrst_dir", 32'(dir), 32'd1);
        chk("midrst_tc", 32'(tc), 32'd0);
        chk("midrst_sticky", 32'(wrap_sticky), 32'd0);

        // load clamp and priority
        reset = 1'b0; mode = 2'b01; max_value = 8'd10; en = 1'b1;
        step_clk();
        step_clk();
        chk("pre_load_out", 32'(out_result), 32'd2);
        load = 1'b1; load_value = 8'd200;
        step_clk();
        chk("load_clamp_out", 32'(out_result), 32'd10);
        chk("load_clamp_tc", 32'(tc), 32'd0);
        reset = 1'b1;
        step_clk();
        chk("load_rst_out", 32'(out_result), 32'd0);
        reset = 1'b0; load = 1'b0;

        // changes of max_value take effect only at the next step
        load = 1'b1; load_value = 8'd7; max_value = 8'd20;
        step_clk();
        chk("load_plain_out", 32'(out_result), 32'd7);
        load = 1'b0; en = 1'b0; max_value = 8'd5;
        step_clk();
        chk("maxchg_hold_out", 32'(out_result), 32'd7);
        en = 1'b1;
        step_clk();
        chk("maxchg_step_out", 32'(out_result), 32'd0);
        chk("maxchg_step_tc", 32'(tc), 32'd1);

        // down wrap and degenerate max_value=0
        reset = 1'b1;
        step_clk();
        reset = 1'b0; mode = 2'b10; max_value = 8'hFF;
        step_clk();
        chk("down_wrap_out", 32'(out_result), 32'hFF);
        chk("down_wrap_tc", 32'(tc), 32'd1);
        step_clk();
        chk("down_dec_out", 32'(out_result), 32'hFE);
        chk("down_dec_tc", 32'(tc), 32'd0);
        max_value = 8'd0;
        step_clk();
        chk("zero_out0", 32'(out_result), 32'd0);
        chk("zero_tc0", 32'(tc), 32'd1);
        clear_flag = 1'b1;
        step_clk();
        chk("zero_out1", 32'(out_result), 32'd0);
        chk("zero_tc1", 32'(tc), 32'd1);
        chk("clr_with_tc_sticky", 32'(wrap_sticky), 32'd1);
        en = 1'b0;
        step_clk();
        chk("clr_alone_sticky", 32'(wrap_sticky), 32'd0);
        chk("clr_alone_tc", 32'(tc), 32'd0);
        clear_flag = 1'b0;
`else
        // prescaled up count, PRESCALE=4
        reset = 1'b0; mode = 2'b01; max_value = 8'd100; en = 1'b1;
        step_clk();
        step_clk();
        step_clk();
        chk("ps_wait_out", 32'(out_result), 32'd0);
        step_clk();
        chk("ps_first_out", 32'(out_result), 32'd1);
        step_clk();
        step_clk();
        en = 1'b0;
        step_clk();
        step_clk();
        step_clk();
        chk("ps_gap_out", 32'(out_result), 32'd1);
        en = 1'b1;
        step_clk();
        chk("ps_resume_out", 32'(out_result), 32'd1);
        step_clk();
        chk("ps_phase_out", 32'(out_result), 32'd2);
        step_clk();
        load = 1'b1; load_value = 8'd7;
        step_clk();
        chk("ps_load_out", 32'(out_result), 32'd7);
        load = 1'b0;
        step_clk();
        step_clk();
        step_clk();
        chk("ps_load_wait_out", 32'(out_result), 32'd7);
        step_clk();
        chk("ps_load_step_out", 32'(out_result), 32'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
